// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, default bit timing and counter width.
// The default bit timing is common to the transmitter and the receiver.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 217;
  localparam int CNT_W = 14;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4,
    ST_BREAK   = 3'd5
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: byte, strobes, frame activity and the FSM state for observation.
// o_RX_DV and o_RX_Frame_Err are single-cycle strobes with no ready; the consumer must take them when they are high.
interface uart_rx_if;
  import uart_pkg::*;

  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Frame_Err;
  logic       o_RX_Active;
  state_t     rx_state;

  modport master (output o_RX_DV, o_RX_Byte, o_RX_Frame_Err, o_RX_Active, rx_state);
  modport slave  (input  o_RX_DV, o_RX_Byte, o_RX_Frame_Err, o_RX_Active, rx_state);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input pin.
// On reset it loads RESET_VAL, which for a UART line is the idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling.
// A good frame produces a one-cycle o_RX_DV; a low stop bit produces a one-cycle o_RX_Frame_Err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_RX_Serial,
  uart_rx_if.master rx
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             err_q, err_d;
  logic             active_q, active_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (i_Clock),
    .rst_n (i_Rst_L),
    .d     (i_RX_Serial),
    .q     (rx_s)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    err_d    = 1'b0;
    active_d = active_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d  = ST_START;
          active_d = 1'b1;
        end
      end
      ST_START: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = ST_CLEANUP;
          end else begin
            err_d    = 1'b1;
            active_d = 1'b0;
            state_d  = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLEANUP: begin
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
      ST_BREAK: begin
        // A held-low line must go high before another start bit is accepted.
        active_d = 1'b0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign rx.o_RX_DV        = dv_q;
  assign rx.o_RX_Byte      = byte_q;
  assign rx.o_RX_Frame_Err = err_q;
  assign rx.o_RX_Active    = active_q;
  assign rx.rx_state       = state_q;

endmodule
